// File: rtl/stitch_pkg.sv
// Shared helpers for the stitched-pipeline credit adapter: ceil-log2 and
// the counter/pointer widths derived from it.
package stitch_pkg;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(n)) r = i + 1;
        end
        return r;
    endfunction

    // Width able to hold 0..depth inclusive (credit / occupancy counters).
    function automatic int unsigned cnt_width(input int unsigned depth);
        return clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stitch_sync_fifo.sv
// WIDTH x DEPTH register FIFO with wrap-around binary pointers and an
// occupancy counter; head data is taken straight from the storage registers.
module stitch_sync_fifo
    import stitch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 5
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_i,
    input  logic [WIDTH-1:0]              data_i,
    input  logic                          pop_i,
    output logic [WIDTH-1:0]              data_o,
    output logic                          valid_o,
    output logic                          full_o,
    output logic [cnt_width(DEPTH)-1:0]   count_o
);
    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        valid_o = (count_q != '0);
        full_o  = (count_q == CW'(DEPTH));
        count_o = count_q;
        data_o  = valid_o ? mem_q[rptr_q] : '0;
        do_pop  = pop_i && valid_o;
        do_push = push_i && (!full_o || do_pop);

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
        if (do_pop)  rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/stitch_credit_adapter.sv
// Valid/ready wrapper around a fixed-latency, stall-free pipeline: launches are
// credit-gated so the output FIFO never overflows; results are blanked after reset.
module stitch_credit_adapter
    import stitch_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LATENCY = 3,
    parameter int unsigned DEPTH   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    output logic             pipe_in_valid,
    input  logic [WIDTH-1:0] pipe_out,
    input  logic             pipe_out_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             protocol_err
);
    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned BW = cnt_width(LATENCY);

    logic [BW-1:0] blank_q, blank_d;
    logic [CW-1:0] used_q, used_d;
    logic          err_q, err_d;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          blanking, pop, live, no_token, overflow, push;

    always_comb begin
        blanking      = (blank_q != '0);
        up_ready      = !blanking && (used_q < CW'(DEPTH));
        pipe_in_valid = up_valid && up_ready;
        pop           = out_valid && out_ready;
        live          = pipe_out_valid && !blanking;
        no_token      = (used_q == fifo_count);
        overflow      = fifo_full && !pop;
        // Spurious results are dropped as well as flagged so used never falls below the FIFO count.
        push          = live && !overflow && !no_token;
        err_d         = err_q || (live && (overflow || no_token));
        blank_d       = blanking ? blank_q - BW'(1) : blank_q;

        used_d = used_q;
        if (pipe_in_valid && !pop)      used_d = used_q + CW'(1);
        else if (pop && !pipe_in_valid) used_d = used_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blank_q <= BW'(LATENCY);
            used_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            blank_q <= blank_d;
            used_q  <= used_d;
            err_q   <= err_d;
        end
    end

    assign protocol_err = err_q;

    stitch_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .data_i  (pipe_out),
        .pop_i   (pop),
        .data_o  (out),
        .valid_o (out_valid),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

endmodule
